cfg_frame_parser: RTL and testbench
===================================

# cfg_frame_parser

Assembles framed configuration packets from the UART receive byte stream (`o_Rx_DV`/`o_Rx_Byte`). Validates each frame's sync byte, inter-byte timing, checksum and repetition count. Atomically publishes the decoded telegram and pulse-timing parameters to the pulse generator and reset-control stages. Sits between `uart_rx` and `gen`/`rst_ctrl`, replacing the unframed 10-byte buffer path with a checked one.

## Interface
- `CLKS_PER_BIT`, 87, UART bit time in `clk` cycles (10 MHz / 115200).
- `TIMEOUT_CLKS`, 1740, maximum idle gap between bytes inside a frame (2 byte times); width of timeout counter is 11 bits.
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `clk  in  1  system clock, 10 MHz`
- `rst_n  in  1  asynchronous active-low reset`
- `rx_dv  in  1  one-cycle strobe: rx_byte valid (from uart_rx o_Rx_DV)`
- `rx_byte  in  8  received byte`
- `tele  out  8  telegram byte`
- `rep_no  out  8  number of repetitions`
- `high_on  out  16  high-phase duration`
- `low_on  out  16  low-phase duration`
- `imp_on  out  16  impulse duration`
- `stop_on  out  16  stop/gap duration`
- `frame_valid  out  1  one-cycle pulse: new parameter set committed`
- `frame_err  out  1  one-cycle pulse: frame discarded`
- `busy  out  1  high while a frame is being assembled`
- `err_cnt  out  8  saturating count of discarded frames`

## Operation
- Frame: SYNC_BYTE, 10 payload bytes, checksum byte (12 bytes total).
- Payload order: tele, rep_no, high_on[15:8], high_on[7:0], low_on MSB, LSB, imp_on MSB, LSB, stop_on MSB, LSB (big-endian).
- Checksum: XOR of the 10 payload bytes.
- Payload is collected into shadow registers. Outputs change only on commit, and all six outputs change together.
- FSM states: IDLE, PAYLOAD, CHECK.
  - IDLE: on rx_dv with rx_byte==SYNC_BYTE → PAYLOAD, byte index=0, running XOR=0. Any other byte is ignored silently, with no error.
  - PAYLOAD: on each rx_dv, store the byte at the current index and XOR it into the running checksum. Index 9 → CHECK, otherwise increment the index. A SYNC_BYTE value here is treated as data.
  - CHECK: on rx_dv, if rx_byte==running XOR and shadow rep_no!=0 → commit, frame_valid. Otherwise → frame_err. Either way → IDLE.
- Timeout: the counter clears on every rx_dv and increments every cycle in PAYLOAD/CHECK. On reaching TIMEOUT_CLKS-1 → frame_err, go to IDLE, shadow registers discarded.
- err_cnt increments on each frame_err and saturates at 8'hFF. It is cleared only by reset.
- busy = (state != IDLE).

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, all outputs 0, including tele/rep_no/durations, pulses and err_cnt.
- Commit latency: the checksum byte's rx_dv in cycle N causes outputs to update and frame_valid=1 in cycle N+1, for exactly 1 cycle.
- frame_err is asserted in the cycle after the failing rx_dv or the timeout terminal count, for 1 cycle.
- frame_valid and frame_err are never asserted together.
- rx_dv arriving in the same cycle as timeout terminal count: the byte wins. The counter clears and no error is raised.
- Back-to-back frames need no gap. A sync byte is accepted in the cycle after return to IDLE.
- Reset mid-frame: the partial frame is lost and published outputs return to 0.
- Published outputs stay stable between commits, regardless of later errors.

## Test plan
- Good frame: A5 64 32 34 08 84 03 98 3A 50 C3 DC → one frame_valid; tele=64, rep_no=32, high_on=3408, low_on=8403, imp_on=983A, stop_on=50C3; err_cnt=0.
- Bad checksum: same frame with last byte DD → frame_err pulse, err_cnt=1, outputs keep their previous values (0 after reset, or the good-frame values if sent after it).
- rep_no zero: A5 64 00 …, with the checksum recomputed as correct → frame_err, no commit.
- Timeout: send A5 64 32, then idle 1740 clocks → frame_err at count 1739, busy falls. The next full good frame commits normally.
- Garbage prefix and sync-as-data: bytes 00 FF 12, then a good frame whose payload contains A5 → no error for the prefix; the frame commits with A5 in the correct field.
- Async reset asserted after byte 6 of a frame → all outputs 0 immediately, state IDLE. The following good frame commits. err_cnt saturates at FF after 260 bad frames.

Source files
------------

// File: rtl/cfg_frame_parser.sv
// Frame parser for UART configuration packets: sync byte, 10 payload bytes, XOR checksum.
// A validated parameter set is published atomically; bad or stalled frames are counted and dropped.
module cfg_frame_parser #(
  parameter int          CLKS_PER_BIT = 87,
  parameter int          TIMEOUT_CLKS = 20 * CLKS_PER_BIT,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic [7:0]  tele,
  output logic [7:0]  rep_no,
  output logic [15:0] high_on,
  output logic [15:0] low_on,
  output logic [15:0] imp_on,
  output logic [15:0] stop_on,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int              TMO_W    = 11;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
  localparam int              N_PAY    = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CHECK
  } state_e;

  typedef struct packed {
    logic [7:0]  tele;
    logic [7:0]  rep_no;
    logic [15:0] high_on;
    logic [15:0] low_on;
    logic [15:0] imp_on;
    logic [15:0] stop_on;
  } params_t;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       shadow_q [N_PAY];
  logic [7:0]       shadow_d [N_PAY];
  params_t          pub_q, pub_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    tmo_d     = tmo_q;
    shadow_d  = shadow_q;
    pub_d     = pub_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (rx_dv && rx_byte == SYNC_BYTE) begin
          state_d = S_PAYLOAD;
          idx_d   = '0;
          csum_d  = '0;
        end
      end

      S_PAYLOAD: begin
        if (rx_dv) begin
          shadow_d[idx_q] = rx_byte;
          csum_d          = csum_q ^ rx_byte;
          tmo_d           = '0;
          if (idx_q == 4'(N_PAY - 1)) state_d = S_CHECK;
          else                        idx_d   = idx_q + 4'd1;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_CHECK: begin
        if (rx_dv) begin
          tmo_d   = '0;
          state_d = S_IDLE;
          if (rx_byte == csum_q && shadow_q[1] != 8'h00) begin
            valid_d = 1'b1;
            pub_d   = '{tele:    shadow_q[0],
                        rep_no:  shadow_q[1],
                        high_on: {shadow_q[2], shadow_q[3]},
                        low_on:  {shadow_q[4], shadow_q[5]},
                        imp_on:  {shadow_q[6], shadow_q[7]},
                        stop_on: {shadow_q[8], shadow_q[9]}};
          end else begin
            err_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      csum_q    <= '0;
      tmo_q     <= '0;
      pub_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      // NOTE: the shadow bank is small register storage, not RAM, so it is reset like any flop.
      for (int i = 0; i < N_PAY; i++) shadow_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      state_q   <= state_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      tmo_q     <= tmo_d;
      pub_q     <= pub_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      for (int i = 0; i < N_PAY; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign tele        = pub_q.tele;
  assign rep_no      = pub_q.rep_no;
  assign high_on     = pub_q.high_on;
  assign low_on      = pub_q.low_on;
  assign imp_on      = pub_q.imp_on;
  assign stop_on     = pub_q.stop_on;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign busy        = (state_q != S_IDLE);
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_cfg_frame_parser.sv
// Scoreboard bench for cfg_frame_parser: expected commits/errors are queued as frames are sent
// and matched against the DUT pulses; published outputs are also checked for stability.
module tb_cfg_frame_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic [7:0]  tele, rep_no, err_cnt;
  logic [15:0] high_on, low_on, imp_on, stop_on;
  logic        frame_valid, frame_err, busy;

  cfg_frame_parser dut (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .tele(tele), .rep_no(rep_no), .high_on(high_on), .low_on(low_on),
    .imp_on(imp_on), .stop_on(stop_on), .frame_valid(frame_valid),
    .frame_err(frame_err), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [79:0] pub;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [79:0] m_pub    = '0;
  logic [7:0]  m_ecnt   = '0;
  logic [79:0] last_pub = '0;
  logic [79:0] pub_now;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [79:0] dut_pub();
    return {tele, rep_no, high_on, low_on, imp_on, stop_on};
  endfunction

  // Monitor: every pulse must match the head of the scoreboard; otherwise outputs must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_pub = '0;
    end else begin
      pub_now = dut_pub();
      if (frame_valid || frame_err) begin
        check("pulse_excl", 80'(frame_valid & frame_err), 80'(0));
        if (sb.size() == 0) begin
          check("unexpected_pulse", 80'({frame_valid, frame_err}), 80'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_is_err", 80'(frame_err), 80'(e.is_err));
          check("pulse_is_valid", 80'(frame_valid), 80'(!e.is_err));
          check("published", pub_now, e.pub);
          check("err_cnt", 80'(err_cnt), 80'(e.ecnt));
          if (!e.is_err) last_pub = e.pub;
        end
      end else begin
        check("pub_stable", pub_now, last_pub);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_byte = b;
    rx_dv   = 1'b1;
    @(negedge clk);
    rx_dv   = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic push_err();
    exp_t e;
    m_ecnt   = (m_ecnt == 8'hFF) ? 8'hFF : m_ecnt + 8'd1;
    e.is_err = 1'b1;
    e.pub    = m_pub;
    e.ecnt   = m_ecnt;
    sb.push_back(e);
  endtask

  // Sends one framed packet; bad corrupts the checksum. stall_len is the gap after byte stall_idx.
  task automatic send_frame(input logic [7:0] t, input logic [7:0] r, input logic [15:0] h,
                            input logic [15:0] l, input logic [15:0] i, input logic [15:0] s,
                            input bit bad, input int stall_idx, input int stall_len,
                            input int max_gap);
    logic [7:0] b [12];
    logic [7:0] x;
    exp_t       e;
    int         gap;
    b = '{8'hA5, t, r, h[15:8], h[7:0], l[15:8], l[7:0], i[15:8], i[7:0], s[15:8], s[7:0], 8'h00};
    x = '0;
    for (int k = 1; k <= 10; k++) x = x ^ b[k];
    b[11] = bad ? (x ^ 8'h01) : x;
    if (bad || r == 8'h00) begin
      push_err();
    end else begin
      m_pub    = {t, r, h, l, i, s};
      e.is_err = 1'b0;
      e.pub    = m_pub;
      e.ecnt   = m_ecnt;
      sb.push_back(e);
    end
    for (int k = 0; k < 12; k++) begin
      if (k == stall_idx) gap = stall_len;
      else if (k == 11)   gap = 0;
      else                gap = int'($urandom_range(0, max_gap));
      send_byte(b[k], gap);
    end
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clk);
    check(tag, 80'(sb.size()), 80'(0));
  endtask

  initial begin
    int  lat;
    bit  seen;
    rst_n   = 1'b0;
    rx_dv   = 1'b0;
    rx_byte = '0;
    repeat (3) @(negedge clk);
    check("rst_pub", dut_pub(), 80'(0));
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_pulses", 80'({frame_valid, frame_err}), 80'(0));
    check("rst_err_cnt", 80'(err_cnt), 80'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame from the reference capture.
    send_frame(8'h64, 8'h32, 16'h3408, 16'h8403, 16'h983A, 16'h50C3, 1'b0, -1, 0, 2);
    drain("good_drain");
    check("good_fields", dut_pub(), {8'h64, 8'h32, 16'h3408, 16'h8403, 16'h983A, 16'h50C3});
    check("good_err_cnt", 80'(err_cnt), 80'(0));

    // Bad checksum (DD instead of DC) and rep_no of zero.
    send_frame(8'h64, 8'h32, 16'h3408, 16'h8403, 16'h983A, 16'h50C3, 1'b1, -1, 0, 2);
    drain("badsum_drain");
    check("badsum_err_cnt", 80'(err_cnt), 80'(1));
    send_frame(8'h64, 8'h00, 16'h3408, 16'h8403, 16'h983A, 16'h50C3, 1'b0, -1, 0, 2);
    drain("rep0_drain");

    // Garbage prefix in IDLE, then a frame carrying A5 in its payload.
    send_byte(8'h00, 1);
    send_byte(8'hFF, 0);
    send_byte(8'h12, 3);
    check("garbage_busy", 80'(busy), 80'(0));
    send_frame(8'hA5, 8'h07, 16'h0102, 16'h12A5, 16'hA5A5, 16'h0000, 1'b0, -1, 0, 1);
    drain("syncdata_drain");

    // Timeout after A5 64 32: error must appear exactly 1740 edges after the last byte.
    push_err();
    send_byte(8'hA5, 0);
    send_byte(8'h64, 0);
    send_byte(8'h32, 0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (lat == 1739) check("busy_before_timeout", 80'(busy), 80'(1));
      if (frame_err) seen = 1'b1;
    end
    check("timeout_latency", 80'(lat), 80'(1740));
    check("busy_after_timeout", 80'(busy), 80'(0));
    send_frame(8'h11, 8'h22, 16'h3344, 16'h5566, 16'h7788, 16'h99AA, 1'b0, -1, 0, 2);
    drain("post_timeout_drain");

    // A byte landing on the terminal-count cycle wins over the timeout.
    send_frame(8'h5A, 8'h03, 16'hBEEF, 16'hCAFE, 16'h1234, 16'h4321, 1'b0, 0, 1739, 0);
    drain("byte_wins_drain");

    // Asynchronous reset after byte 6 of a frame.
    send_byte(8'hA5, 0);
    for (int k = 1; k <= 6; k++) send_byte(8'(k * 17), 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pub", dut_pub(), 80'(0));
    check("midrst_busy", 80'(busy), 80'(0));
    check("midrst_err_cnt", 80'(err_cnt), 80'(0));
    m_pub  = '0;
    m_ecnt = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    send_frame(8'h64, 8'h32, 16'h3408, 16'h8403, 16'h983A, 16'h50C3, 1'b0, -1, 0, 2);
    drain("post_reset_drain");

    // 260 back-to-back bad frames saturate the error counter.
    for (int n = 0; n < 260; n++)
      send_frame(8'(n), 8'h01, 16'(n * 3), 16'h0F0F, 16'h00FF, 16'hFF00, 1'b1, -1, 0, 0);
    drain("sat_drain");
    check("sat_err_cnt", 80'(err_cnt), 80'(8'hFF));
    check("sat_pub_kept", dut_pub(), {8'h64, 8'h32, 16'h3408, 16'h8403, 16'h983A, 16'h50C3});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
